wb_sram_slave: RTL and testbench

Pipelined Wishbone B4 responder that terminates one slave port of the SoC crossbar with an on-chip word-addressed RAM. It accepts one request per cycle and returns ack (or err for out-of-range words) a fixed number of cycles later, with byte-lane writes via sel. It zero-fills its memory after every reset, stalling the bus during the sweep. Requests are dropped when the master releases cyc.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_if.sv | 28 ++
 rtl/wb_resp_pipe.sv | 32 +++
 rtl/wb_sram_slave.sv | 102 ++++++++++
 tb/tb_wb_sram_slave.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Wishbone B4 types shared by the crossbar slave ports, plus the response-stage
// payload used by pipelined slaves.
package wb_pkg;

  typedef logic [31:0] adr_t;
  typedef logic [31:0] dat_t;
  typedef logic [3:0]  sel_t;

  typedef struct packed {
    logic valid;
    logic err;
    dat_t data;
  } resp_t;

  typedef enum logic {
    StInit = 1'b0,
    StRun  = 1'b1
  } sram_state_e;

endpackage

// File: rtl/wb_if.sv
// Wishbone B4 pipelined bus bundle; clk and rst travel with the bus.
interface wb_if;
  import wb_pkg::*;

  logic clk;
  logic rst;
  logic cyc;
  logic stb;
  logic we;
  adr_t adr;
  sel_t sel;
  dat_t dat_i;
  dat_t dat_o;
  logic stall;
  logic ack;
  logic err;

  modport slave (
    input  clk, rst, cyc, stb, we, adr, sel, dat_i,
    output dat_o, stall, ack, err
  );

  modport master (
    input  clk, rst, dat_o, stall, ack, err,
    output cyc, stb, we, adr, sel, dat_i
  );

endinterface

// File: rtl/wb_resp_pipe.sv
// Fixed-depth response shift register for pipelined Wishbone slaves.
// A flush clears every stage so in-flight responses are never signalled.
module wb_resp_pipe
  import wb_pkg::*;
#(
  parameter int unsigned latency = 1
) (
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_flush,
  input  resp_t i_resp,
  output resp_t o_resp
);

  resp_t r_stage [latency];

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      for (int i = 0; i < int'(latency); i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_resp;
      for (int i = 1; i < int'(latency); i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_resp = r_stage[latency-1];

endmodule

// File: rtl/wb_sram_slave.sv
// Pipelined Wishbone B4 slave backed by a word-addressed RAM. Zero-fills the
// RAM after every reset while stalling, then accepts one request per cycle.
module wb_sram_slave
  import wb_pkg::*;
#(
  parameter int unsigned words   = 1024,
  parameter int unsigned latency = 1
) (
  wb_if.slave wb
);

  localparam int unsigned IdxW = (words > 1) ? $clog2(words) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(words - 1);

  sram_state_e     r_state;
  logic [IdxW-1:0] r_init_cnt;
  logic            r_stall;
  dat_t            r_mem [words];

  logic [IdxW-1:0] w_idx;
  logic            w_in_range;
  logic            w_accept;
  logic            w_wr_en;
  logic            w_flush;
  resp_t           w_resp_in;
  resp_t           w_resp_out;
  logic            w_unused;

  // The crossbar has already decoded the base, so only the word field matters.
  assign w_idx      = wb.adr[2 +: IdxW];
  assign w_unused   = ^{wb.adr[31:2+IdxW], wb.adr[1:0]};
  assign w_in_range = 32'(w_idx) < words;
  assign w_accept   = wb.cyc & wb.stb & ~r_stall;
  assign w_wr_en    = w_accept & wb.we & w_in_range;
  assign w_flush    = ~wb.cyc;

  always_ff @(posedge wb.clk) begin
    if (wb.rst) begin
      r_state    <= StInit;
      r_init_cnt <= '0;
      r_stall    <= 1'b1;
    end else begin
      unique case (r_state)
        StInit: begin
          if (r_init_cnt == LastIdx) begin
            r_state <= StRun;
            r_stall <= 1'b0;
          end else begin
            r_init_cnt <= r_init_cnt + 1'b1;
          end
        end
        StRun: begin
          r_stall <= 1'b0;
        end
        default: begin
          r_state <= StInit;
          r_stall <= 1'b1;
        end
      endcase
    end
  end

  // Sweep port has priority; bus writes cannot be accepted while stalled anyway.
  always_ff @(posedge wb.clk) begin
    if (r_state == StInit) begin
      r_mem[r_init_cnt] <= '0;
    end else if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wb.sel[b]) begin
          r_mem[w_idx][8*b +: 8] <= wb.dat_i[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    w_resp_in = '0;
    if (w_accept) begin
      w_resp_in.valid = 1'b1;
      w_resp_in.err   = ~w_in_range;
      if (w_in_range && !wb.we) begin
        w_resp_in.data = r_mem[w_idx];
      end
    end
  end

  wb_resp_pipe #(
    .latency (latency)
  ) u_resp_pipe (
    .i_clk   (wb.clk),
    .i_rst   (wb.rst),
    .i_flush (w_flush),
    .i_resp  (w_resp_in),
    .o_resp  (w_resp_out)
  );

  assign wb.stall = r_stall;
  assign wb.ack   = w_resp_out.valid & ~w_resp_out.err;
  assign wb.err   = w_resp_out.valid & w_resp_out.err;
  assign wb.dat_o = (w_resp_out.valid & ~w_resp_out.err) ? w_resp_out.data : '0;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Self-checking bench: three slave configurations share one stimulus stream,
// and each check looks only at the configuration selected by dsel.
module tb_wb_sram_slave;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cyc = 1'b0;
  logic stb = 1'b0;
  logic we  = 1'b0;
  adr_t adr = '0;
  sel_t sel = '0;
  dat_t dat = '0;

  always #5 clk = ~clk;

  wb_if bus0 ();
  wb_if bus1 ();
  wb_if bus2 ();

  assign bus0.clk = clk;  assign bus1.clk = clk;  assign bus2.clk = clk;
  assign bus0.rst = rst;  assign bus1.rst = rst;  assign bus2.rst = rst;
  assign bus0.cyc = cyc;  assign bus1.cyc = cyc;  assign bus2.cyc = cyc;
  assign bus0.stb = stb;  assign bus1.stb = stb;  assign bus2.stb = stb;
  assign bus0.we  = we;   assign bus1.we  = we;   assign bus2.we  = we;
  assign bus0.adr = adr;  assign bus1.adr = adr;  assign bus2.adr = adr;
  assign bus0.sel = sel;  assign bus1.sel = sel;  assign bus2.sel = sel;
  assign bus0.dat_i = dat; assign bus1.dat_i = dat; assign bus2.dat_i = dat;

  wb_sram_slave #(.words(16), .latency(1)) u_dut0 (.wb(bus0.slave));
  wb_sram_slave #(.words(16), .latency(2)) u_dut1 (.wb(bus1.slave));
  wb_sram_slave #(.words(12), .latency(3)) u_dut2 (.wb(bus2.slave));

  int   dsel = 0;
  int   lat_of [3] = '{1, 2, 3};
  logic s_ack, s_err, s_stall;
  dat_t s_dat;

  assign s_ack   = (dsel == 0) ? bus0.ack   : (dsel == 1) ? bus1.ack   : bus2.ack;
  assign s_err   = (dsel == 0) ? bus0.err   : (dsel == 1) ? bus1.err   : bus2.err;
  assign s_stall = (dsel == 0) ? bus0.stall : (dsel == 1) ? bus1.stall : bus2.stall;
  assign s_dat   = (dsel == 0) ? bus0.dat_o : (dsel == 1) ? bus1.dat_o : bus2.dat_o;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  task automatic check_xfer(input string name, input logic a, input logic e, input dat_t d,
                            input int n, input logic ea, input logic ee, input dat_t ed,
                            input int en);
    n_checks++;
    if (a !== ea || e !== ee || d !== ed || n != en) begin
      n_fail++;
      $display("FAIL %s: got ack=%0b err=%0b dat=%h cyc=%0d, want ack=%0b err=%0b dat=%h cyc=%0d",
               name, a, e, d, n, ea, ee, ed, en);
    end
  endtask

  // Single transaction, preceded by a cyc=0 cycle that flushes every pipeline.
  logic x_ack, x_err;
  dat_t x_dat;
  int   x_n;

  task automatic xfer(input logic t_we, input adr_t t_adr, input sel_t t_sel, input dat_t t_dat);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = t_we; adr = t_adr; sel = t_sel; dat = t_dat;
    @(posedge clk); #1;
    stb = 1'b0;
    x_n = 1;
    while (!(s_ack || s_err) && x_n < 8) begin
      @(posedge clk); #1;
      x_n++;
    end
    x_ack = s_ack; x_err = s_err; x_dat = s_dat;
  endtask

  // Back-to-back burst; mode 1 drops cyc after the last request, mode 2 asserts rst.
  logic b_we  [8];
  adr_t b_adr [8];
  dat_t b_dat [8];
  int   r_cyc [8];
  dat_t r_dat [8];
  int   r_cnt, r_errs;

  task automatic run_burst(input int n, input int mode, input int cycles);
    r_cnt = 0; r_errs = 0;
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < cycles; c++) begin
      if (c < n) begin
        cyc = 1'b1; stb = 1'b1; we = b_we[c]; adr = b_adr[c]; sel = 4'hF; dat = b_dat[c];
      end else begin
        stb = 1'b0;
        cyc = !(c == n && mode == 1);
        rst = (c == n && mode == 2);
      end
      @(posedge clk); #1;
      if (s_ack) begin
        if (r_cnt < 8) begin
          r_cyc[r_cnt] = c + 1;
          r_dat[r_cnt] = s_dat;
        end
        r_cnt++;
      end
      if (s_err) r_errs++;
    end
    stb = 1'b0; cyc = 1'b1; rst = 1'b0;
  endtask

  int w_cnt, w_spur;

  task automatic wait_run();
    w_cnt = 0; w_spur = 0;
    while (s_stall && w_cnt < 100) begin
      if (s_ack || s_err) w_spur++;
      w_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_stall"}, 32'(s_stall), 32'd1);
    check_val({tag, "_ack"},   32'(s_ack),   32'd0);
    check_val({tag, "_err"},   32'(s_err),   32'd0);
    check_val({tag, "_dat"},   s_dat,        32'd0);
  endtask

  typedef struct {
    int   dut;
    logic we;
    adr_t adr;
    sel_t sel;
    dat_t dat;
    logic ack;
    logic err;
    dat_t rdat;
  } vec_t;

  localparam int NV = 16;
  vec_t vt [NV];

  initial begin
    vt[0]  = '{0, 1'b1, 32'h0000_0000, 4'hF, 32'h1122_3344, 1'b1, 1'b0, 32'h0};
    vt[1]  = '{0, 1'b0, 32'h0000_0000, 4'hF, 32'h0,         1'b1, 1'b0, 32'h1122_3344};
    vt[2]  = '{0, 1'b1, 32'h0000_0004, 4'h3, 32'hAABB_CCDD, 1'b1, 1'b0, 32'h0};
    vt[3]  = '{0, 1'b1, 32'h0000_0004, 4'hC, 32'h5566_7788, 1'b1, 1'b0, 32'h0};
    vt[4]  = '{0, 1'b0, 32'h0000_0004, 4'hF, 32'h0,         1'b1, 1'b0, 32'h5566_CCDD};
    vt[5]  = '{0, 1'b1, 32'h0000_0008, 4'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0};
    vt[6]  = '{0, 1'b0, 32'h0000_0008, 4'hF, 32'h0,         1'b1, 1'b0, 32'h0};
    vt[7]  = '{0, 1'b0, 32'h0000_0043, 4'hF, 32'h0,         1'b1, 1'b0, 32'h1122_3344};
    vt[8]  = '{0, 1'b0, 32'hFFFF_FFC4, 4'hF, 32'h0,         1'b1, 1'b0, 32'h5566_CCDD};
    vt[9]  = '{0, 1'b1, 32'h0000_003C, 4'hF, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0};
    vt[10] = '{0, 1'b0, 32'h0000_003C, 4'hF, 32'h0,         1'b1, 1'b0, 32'hCAFE_F00D};
    vt[11] = '{2, 1'b0, 32'h0000_0030, 4'hF, 32'h0,         1'b0, 1'b1, 32'h0};
    vt[12] = '{2, 1'b1, 32'h0000_002C, 4'hF, 32'h1234_5678, 1'b1, 1'b0, 32'h0};
    vt[13] = '{2, 1'b0, 32'h0000_002C, 4'hF, 32'h0,         1'b1, 1'b0, 32'h1234_5678};
    vt[14] = '{2, 1'b0, 32'h0000_003C, 4'hF, 32'h0,         1'b0, 1'b1, 32'h0};
    vt[15] = '{2, 1'b1, 32'h0000_0034, 4'hF, 32'hFFFF_0000, 1'b0, 1'b1, 32'h0};

    // Reset and zero-fill sweep.
    dsel = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_vals("rst0");
    wait_run();
    check_val("init_stall_cycles", 32'(w_cnt), 32'd16);
    check_val("init_spurious", 32'(w_spur), 32'd0);

    for (int i = 0; i < 16; i++) begin
      xfer(1'b0, adr_t'(4 * i), 4'hF, 32'h0);
      check_xfer($sformatf("zero_rd%0d", i), x_ack, x_err, x_dat, x_n, 1'b1, 1'b0, 32'h0, 1);
    end

    for (int i = 0; i < NV; i++) begin
      dsel = vt[i].dut;
      xfer(vt[i].we, vt[i].adr, vt[i].sel, vt[i].dat);
      check_xfer($sformatf("vec%0d", i), x_ack, x_err, x_dat, x_n,
                 vt[i].ack, vt[i].err, vt[i].rdat, lat_of[vt[i].dut]);
    end

    // Partial-lane write with latency 2.
    dsel = 1;
    xfer(1'b1, 32'h10, 4'b0101, 32'hDEAD_BEEF);
    check_xfer("lat2_wr", x_ack, x_err, x_dat, x_n, 1'b1, 1'b0, 32'h0, 2);
    xfer(1'b0, 32'h10, 4'hF, 32'h0);
    check_xfer("lat2_rd", x_ack, x_err, x_dat, x_n, 1'b1, 1'b0, 32'h00AD_00EF, 2);

    // Read-after-write on consecutive cycles, latency 1.
    dsel = 0;
    b_we[0] = 1'b1; b_adr[0] = 32'h20; b_dat[0] = 32'h0BAD_CAFE;
    b_we[1] = 1'b0; b_adr[1] = 32'h20; b_dat[1] = 32'h0;
    run_burst(2, 0, 5);
    check_val("raw_count", 32'(r_cnt), 32'd2);
    check_val("raw_wr_cyc", 32'(r_cyc[0]), 32'd1);
    check_val("raw_rd_cyc", 32'(r_cyc[1]), 32'd2);
    check_val("raw_rd_dat", r_dat[1], 32'h0BAD_CAFE);

    // Four writes then four pipelined reads, latency 3.
    dsel = 2;
    for (int i = 0; i < 8; i++) begin
      b_we[i]  = (i < 4);
      b_adr[i] = adr_t'(4 * (i % 4));
      b_dat[i] = (i < 4) ? dat_t'(i + 1) : 32'h0;
    end
    run_burst(8, 0, 14);
    check_val("pipe_count", 32'(r_cnt), 32'd8);
    check_val("pipe_errs", 32'(r_errs), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("pipe_cyc%0d", i), 32'(r_cyc[i]), 32'(i + 3));
      check_val($sformatf("pipe_dat%0d", i), r_dat[i], (i < 4) ? 32'h0 : 32'(i - 3));
    end

    // cyc drop with two reads in flight.
    b_we[0] = 1'b0; b_adr[0] = 32'h04;
    b_we[1] = 1'b0; b_adr[1] = 32'h08;
    run_burst(2, 1, 8);
    check_val("abort_acks", 32'(r_cnt), 32'd0);
    check_val("abort_errs", 32'(r_errs), 32'd0);
    xfer(1'b0, 32'h08, 4'hF, 32'h0);
    check_xfer("after_abort_rd", x_ack, x_err, x_dat, x_n, 1'b1, 1'b0, 32'h3, 3);

    // Reset with two reads in flight; memory must be rezeroed.
    run_burst(2, 2, 3);
    check_val("rst_mid_acks", 32'(r_cnt), 32'd0);
    check_val("rst_mid_errs", 32'(r_errs), 32'd0);
    cyc = 1'b0;
    check_reset_vals("rst2");
    wait_run();
    check_val("reinit_stall_cycles", 32'(w_cnt), 32'd12);
    check_val("reinit_spurious", 32'(w_spur), 32'd0);
    xfer(1'b0, 32'h08, 4'hF, 32'h0);
    check_xfer("rezeroed_rd", x_ack, x_err, x_dat, x_n, 1'b1, 1'b0, 32'h0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // ack and err must never be asserted together on any configuration.
  always @(negedge clk) begin
    if ((bus0.ack & bus0.err) | (bus1.ack & bus1.err) | (bus2.ack & bus2.err)) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_err_exclusive: both high at %0t", $time);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
